dvfs_transition_sequencer: RTL and testbench
============================================

// Module: dvfs_transition_sequencer
// PURPOSE
//  Sits between the DPMU policy FSM and the voltage regulator / clock generators. Takes
//  per-domain V/F targets for core1, core2 and mem, and applies them one domain at a time.
//  Ordering is always safe: when voltage rises, V is applied before F; otherwise F is
//  applied before V. Domains share one regulator port and are granted round-robin.
// PARAMETERS
//  VW          2   voltage level width per domain
//  FW          3   frequency level width per domain
//  SETTLE_CYC  16  regulator settle cycles after ack (>=1)
//  FLOCK_CYC   8   clock-gen lock cycles after F change (>=1)
//  CNTW        5   settle/lock counter width; must hold max(SETTLE_CYC,FLOCK_CYC)-1
//  RST_V       2'b01   per-domain voltage at reset
//  RST_F       3'b010  per-domain frequency at reset
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      async active-low reset
//  tgt_v      in   3*VW   target V; [VW-1:0]=core1, next=core2, MSBs=mem
//  tgt_f      in   3*FW   target F; same packing as tgt_v
//  hold       in   1      1 = start no new transition
//  vreg_ack   in   1      regulator accepted request (level, sampled only while vreg_req=1)
//  vreg_req   out  1      regulator request
//  vreg_dom   out  2      domain of request (0=core1,1=core2,2=mem)
//  vreg_lvl   out  VW     requested voltage level
//  cur_v      out  3*VW   applied voltages (same packing)
//  cur_f      out  3*FW   applied frequencies
//  busy       out  1      1 whenever state != IDLE
//  done       out  1      one-cycle pulse when a domain transition completes
//  act_dom    out  2      domain being sequenced; valid while busy
// BEHAVIOUR
//  Reset: cur_v=RST_V and cur_f=RST_F for all domains. vreg_req=0, busy=0, done=0,
//   act_dom=0, rr_ptr=0, state=IDLE. Reset mid-operation aborts at once; vreg_req drops.
//  Pending(d): tgt_v[d]!=cur_v[d] or tgt_f[d]!=cur_f[d]. All outputs are registered.
//  States: IDLE, V_REQ, V_SETTLE, F_LOCK, COMPLETE.
//  IDLE: if hold=0 and any domain is pending, pick the first pending domain scanning
//   rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Latch dom, snap_v=tgt_v[dom], snap_f=tgt_f[dom].
//   - If snap_v>cur_v, go to V_REQ.
//   - Else if snap_f!=cur_f, go to F_LOCK.
//   - Else go to V_REQ.
//  V_REQ: vreg_req=1, vreg_dom=dom, vreg_lvl=snap_v; these are held stable until ack.
//   On the edge sampling vreg_ack=1: cur_v[dom]<=snap_v, vreg_req<=0, cnt<=SETTLE_CYC-1,
//   go to V_SETTLE. Ack seen while vreg_req=0 is ignored.
//  V_SETTLE: lasts exactly SETTLE_CYC cycles, with cnt decrementing. At cnt==0:
//   if snap_f!=cur_f[dom], go to F_LOCK, else go to COMPLETE.
//  F_LOCK entry edge: cur_f[dom]<=snap_f and cnt<=FLOCK_CYC-1. The state lasts FLOCK_CYC
//   cycles. At cnt==0: if snap_v!=cur_v[dom], go to V_REQ, else go to COMPLETE.
//  COMPLETE: one cycle with done=1. rr_ptr<=(dom+1) mod 3, then go to IDLE.
//   A back-to-back pending domain starts on the following IDLE cycle.
//  Compares are unsigned. Only one domain's cur_v/cur_f changes per transition.
//  tgt changes mid-transition are ignored (snapshot is used) and re-evaluated in IDLE.
//  hold rising mid-transition does not abort; the transition finishes, then the block idles.
//  Unused state encodings return to IDLE.
// TESTING
//  1 Reset, tgt=reset values -> busy=0, cur_v=6'b010101, cur_f=9'b010010010, no vreg_req.
//  2 core1 tgt 01->11 / 010->111, ack 2 cycles after req -> vreg_lvl=11; cur_v0=11 on ack edge;
//    cur_f0=111 SETTLE_CYC cycles later; done pulse FLOCK_CYC cycles after that.
//  3 mem tgt 01->00 / 010->000 -> cur_f2=000 first, then vreg_req with lvl=00;
//    cur_v2=00 on ack; done SETTLE_CYC cycles later.
//  4 All 3 domains pending, rr_ptr=0 -> order core1, core2, mem; rerun with rr_ptr=1 -> core2 first.
//  5 Change tgt_v0 during V_SETTLE -> current transition completes with snapshot;
//    new transition starts after done.
//  6 rst_n low during V_REQ -> vreg_req=0 and cur_* at reset values immediately;
//    hold=1 with pending -> busy stays 0.

Source files
------------

// File: rtl/dvfs_transition_sequencer.sv
// dvfs_transition_sequencer
// Applies per-domain voltage/frequency targets for core1, core2 and mem one
// domain at a time over a shared regulator port. When the voltage rises, V is
// applied before F; otherwise F is applied before V. Domains are served in
// round-robin order starting from rr_ptr.
module dvfs_transition_sequencer #(
  parameter int             VW         = 2,
  parameter int             FW         = 3,
  parameter int             SETTLE_CYC = 16,
  parameter int             FLOCK_CYC  = 8,
  parameter int             CNTW       = 5,
  parameter logic [VW-1:0]  RST_V      = 2'b01,
  parameter logic [FW-1:0]  RST_F      = 3'b010
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3*VW-1:0] tgt_v,
  input  logic [3*FW-1:0] tgt_f,
  input  logic            hold,
  input  logic            vreg_ack,
  output logic            vreg_req,
  output logic [1:0]      vreg_dom,
  output logic [VW-1:0]   vreg_lvl,
  output logic [3*VW-1:0] cur_v,
  output logic [3*FW-1:0] cur_f,
  output logic            busy,
  output logic            done,
  output logic [1:0]      act_dom
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    V_REQ    = 3'd1,
    V_SETTLE = 3'd2,
    F_LOCK   = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [2:0][VW-1:0]    tv, cv;
  logic [2:0][FW-1:0]    tf, cf;
  logic [2:0]            pending;
  logic                  pick_valid;
  logic [1:0]            pick_dom, rr_ptr, dom;
  logic [VW-1:0]         snap_v;
  logic [FW-1:0]         snap_f;
  logic [CNTW-1:0]       cnt;
  logic [1:0]            ent_dom;
  logic [FW-1:0]         ent_f;
  logic                  vreg_req_q, busy_q, done_q;

  assign tv       = tgt_v;
  assign tf       = tgt_f;
  assign cur_v    = cv;
  assign cur_f    = cf;
  assign vreg_req = vreg_req_q;
  assign vreg_dom = dom;
  assign vreg_lvl = snap_v;
  assign busy     = busy_q;
  assign done     = done_q;
  assign act_dom  = dom;

  // Find the first pending domain, scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pending  = '0;
    pick_dom = rr_ptr;
    for (int d = 0; d < 3; d++) begin
      pending[d] = (tv[d] != cv[d]) || (tf[d] != cf[d]);
    end
    pick_valid = |pending;
    // Walk from farthest to nearest so the nearest pending domain wins.
    for (int k = 2; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= 3) idx = idx - 3;
      if (pending[idx]) pick_dom = 2'(idx);
    end
  end

  // Domain/frequency written on F_LOCK entry: freshly picked in IDLE, else the latched one.
  always_comb begin
    ent_dom = dom;
    ent_f   = snap_f;
    if (state == IDLE) begin
      ent_dom = pick_dom;
      ent_f   = tf[pick_dom];
    end
  end

  // Next-state logic for the V/F ordering sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!hold && pick_valid) begin
          if (tv[pick_dom] > cv[pick_dom])       state_next = V_REQ;
          else if (tf[pick_dom] != cf[pick_dom]) state_next = F_LOCK;
          else                                   state_next = V_REQ;
        end
      end
      V_REQ:    if (vreg_req_q && vreg_ack) state_next = V_SETTLE;
      V_SETTLE: if (cnt == '0) state_next = (snap_f != cf[dom]) ? F_LOCK : COMPLETE;
      F_LOCK:   if (cnt == '0) state_next = (snap_v != cv[dom]) ? V_REQ : COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so all flops update together.
    else        state <= state_next;
  end

  // Datapath: snapshot, applied V/F, settle/lock counter, round-robin pointer, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the applied V/F array is architectural state, so it is reset like any control flop.
      cv         <= {3{RST_V}};
      cf         <= {3{RST_F}};
      dom        <= '0;
      rr_ptr     <= '0;
      snap_v     <= '0;
      snap_f     <= '0;
      cnt        <= '0;
      vreg_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      vreg_req_q <= (state_next == V_REQ);
      busy_q     <= (state_next != IDLE);
      done_q     <= (state_next == COMPLETE);

      if (state == IDLE && state_next != IDLE) begin
        dom    <= pick_dom;
        snap_v <= tv[pick_dom];
        snap_f <= tf[pick_dom];
      end

      if (state == V_REQ && state_next == V_SETTLE) begin
        cv[dom] <= snap_v;
        cnt     <= CNTW'(SETTLE_CYC - 1);
      end else if (state_next == F_LOCK && state != F_LOCK) begin
        cf[ent_dom] <= ent_f;
        cnt         <= CNTW'(FLOCK_CYC - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (state == COMPLETE) rr_ptr <= (dom == 2'd2) ? 2'd0 : dom + 2'd1;
    end
  end

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Directed testbench for dvfs_transition_sequencer (default parameters).
module tb_dvfs_transition_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] tgt_v;
  logic [8:0] tgt_f;
  logic       hold;
  logic       vreg_ack;
  logic       vreg_req;
  logic [1:0] vreg_dom;
  logic [1:0] vreg_lvl;
  logic [5:0] cur_v;
  logic [8:0] cur_f;
  logic       busy;
  logic       done;
  logic [1:0] act_dom;
  logic [4:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  dvfs_transition_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt_v    (tgt_v),
    .tgt_f    (tgt_f),
    .hold     (hold),
    .vreg_ack (vreg_ack),
    .vreg_req (vreg_req),
    .vreg_dom (vreg_dom),
    .vreg_lvl (vreg_lvl),
    .cur_v    (cur_v),
    .cur_f    (cur_f),
    .busy     (busy),
    .done     (done),
    .act_dom  (act_dom)
  );

  // {vreg_req, busy, done, act_dom}
  assign ctl = {vreg_req, busy, done, act_dom};

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tgt_v = 6'b010101; tgt_f = 9'b010010010; hold = 1'b0; vreg_ack = 1'b0;
    tick(2);
    n_vec++; if (cur_v !== 6'b010101) begin n_err++; $display("FAIL reset_cur_v got=%b want=%b", cur_v, 6'b010101); end
    n_vec++; if (cur_f !== 9'b010010010) begin n_err++; $display("FAIL reset_cur_f got=%b want=%b", cur_f, 9'b010010010); end
    n_vec++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL reset_ctl got=%b want=%b", ctl, 5'b00000); end
    rst_n = 1'b1;
    vreg_ack = 1'b1;  // ack while no request must be ignored
    tick(3);
    vreg_ack = 1'b0;
    n_vec++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL idle_ctl got=%b want=%b", ctl, 5'b00000); end
    n_vec++; if (cur_v !== 6'b010101) begin n_err++; $display("FAIL idle_ack_cur_v got=%b want=%b", cur_v, 6'b010101); end
  endtask

  // core1 01->11 / 010->111: V first, then F.
  task automatic test_v_up();
    tgt_v = 6'b01_01_11; tgt_f = 9'b010_010_111;
    tick();
    n_vec++; if (ctl !== 5'b11000) begin n_err++; $display("FAIL vup_req_ctl got=%b want=%b", ctl, 5'b11000); end
    n_vec++; if ({vreg_dom, vreg_lvl} !== 4'b0011) begin n_err++; $display("FAIL vup_req_lvl got=%b want=%b", {vreg_dom, vreg_lvl}, 4'b0011); end
    tick(2);
    n_vec++; if (ctl !== 5'b11000 || cur_v !== 6'b010101) begin n_err++; $display("FAIL vup_req_held got=%b/%b want=11000/010101", ctl, cur_v); end
    vreg_ack = 1'b1; tick(); vreg_ack = 1'b0;
    n_vec++; if (cur_v !== 6'b010111) begin n_err++; $display("FAIL vup_cur_v got=%b want=%b", cur_v, 6'b010111); end
    n_vec++; if (ctl !== 5'b01000) begin n_err++; $display("FAIL vup_settle_ctl got=%b want=%b", ctl, 5'b01000); end
    tick(15);
    n_vec++; if (cur_f !== 9'b010010010) begin n_err++; $display("FAIL vup_f_early got=%b want=%b", cur_f, 9'b010010010); end
    tick();
    n_vec++; if (cur_f !== 9'b010010111) begin n_err++; $display("FAIL vup_cur_f got=%b want=%b", cur_f, 9'b010010111); end
    tick(7);
    n_vec++; if (ctl !== 5'b01000) begin n_err++; $display("FAIL vup_lock_ctl got=%b want=%b", ctl, 5'b01000); end
    tick();
    n_vec++; if (ctl !== 5'b01100) begin n_err++; $display("FAIL vup_done got=%b want=%b", ctl, 5'b01100); end
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL vup_idle got=%b want=00", {busy, done}); end
  endtask

  // mem 01->00 / 010->000: F first, then V.
  task automatic test_f_down();
    tgt_v = 6'b00_01_11; tgt_f = 9'b000_010_111;
    tick();
    n_vec++; if (cur_f !== 9'b000010111) begin n_err++; $display("FAIL fdn_cur_f got=%b want=%b", cur_f, 9'b000010111); end
    n_vec++; if (ctl !== 5'b01010) begin n_err++; $display("FAIL fdn_lock_ctl got=%b want=%b", ctl, 5'b01010); end
    tick(7);
    n_vec++; if (vreg_req !== 1'b0 || cur_v !== 6'b010111) begin n_err++; $display("FAIL fdn_no_req got=%b/%b want=0/010111", vreg_req, cur_v); end
    tick();
    n_vec++; if (ctl !== 5'b11010 || {vreg_dom, vreg_lvl} !== 4'b1000) begin n_err++; $display("FAIL fdn_req got=%b/%b want=11010/1000", ctl, {vreg_dom, vreg_lvl}); end
    vreg_ack = 1'b1; tick(); vreg_ack = 1'b0;
    n_vec++; if (cur_v !== 6'b000111) begin n_err++; $display("FAIL fdn_cur_v got=%b want=%b", cur_v, 6'b000111); end
    tick(15);
    n_vec++; if (ctl !== 5'b01010) begin n_err++; $display("FAIL fdn_settle_ctl got=%b want=%b", ctl, 5'b01010); end
    tick();
    n_vec++; if (ctl !== 5'b01110) begin n_err++; $display("FAIL fdn_done got=%b want=%b", ctl, 5'b01110); end
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL fdn_idle got=%b want=00", {busy, done}); end
  endtask

  // One frequency-only transition on domain d, back to back with the previous one.
  task automatic run_f(input logic [1:0] d, input logic [8:0] exp_f, input string name);
    tick();
    n_vec++; if (ctl !== {3'b010, d} || cur_f !== exp_f) begin n_err++; $display("FAIL %s_start got=%b/%b want=%b/%b", name, ctl, cur_f, {3'b010, d}, exp_f); end
    tick(7);
    n_vec++; if (ctl !== {3'b010, d}) begin n_err++; $display("FAIL %s_lock got=%b want=%b", name, ctl, {3'b010, d}); end
    tick();
    n_vec++; if (ctl !== {3'b011, d}) begin n_err++; $display("FAIL %s_done got=%b want=%b", name, ctl, {3'b011, d}); end
    tick();
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL %s_idle got=%b want=00", name, {busy, done}); end
  endtask

  task automatic test_round_robin();
    tgt_f = 9'b001_011_110;
    run_f(2'd0, 9'b000_010_110, "rr0_a");
    run_f(2'd1, 9'b000_011_110, "rr0_b");
    run_f(2'd2, 9'b001_011_110, "rr0_c");
    tgt_f = 9'b001_011_111;
    run_f(2'd0, 9'b001_011_111, "rr_set");
    tgt_f = 9'b010_100_101;
    run_f(2'd1, 9'b001_100_111, "rr1_a");
    run_f(2'd2, 9'b010_100_111, "rr1_b");
    run_f(2'd0, 9'b010_100_101, "rr1_c");
    n_vec++; if (cur_v !== 6'b000111) begin n_err++; $display("FAIL rr_cur_v got=%b want=%b", cur_v, 6'b000111); end
  endtask

  // core1 11->10 with tgt changed to 00 during settle: snapshot finishes, then a new run.
  task automatic test_snapshot();
    tgt_v = 6'b00_01_10;
    tick();
    n_vec++; if (ctl !== 5'b11000 || vreg_lvl !== 2'b10) begin n_err++; $display("FAIL snap_req got=%b/%b want=11000/10", ctl, vreg_lvl); end
    vreg_ack = 1'b1; tick(); vreg_ack = 1'b0;
    tick(3);
    tgt_v = 6'b00_01_00;
    tick(12);
    n_vec++; if (cur_v !== 6'b000110 || ctl !== 5'b01000) begin n_err++; $display("FAIL snap_settle got=%b/%b want=000110/01000", cur_v, ctl); end
    tick();
    n_vec++; if (ctl !== 5'b01100) begin n_err++; $display("FAIL snap_done got=%b want=%b", ctl, 5'b01100); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL snap_idle got=%b want=0", busy); end
    tick();
    n_vec++; if (ctl !== 5'b11000 || vreg_lvl !== 2'b00) begin n_err++; $display("FAIL snap_rerun got=%b/%b want=11000/00", ctl, vreg_lvl); end
    vreg_ack = 1'b1; tick(); vreg_ack = 1'b0;
    n_vec++; if (cur_v !== 6'b000100) begin n_err++; $display("FAIL snap_cur_v got=%b want=%b", cur_v, 6'b000100); end
    tick(16);
    n_vec++; if (ctl !== 5'b01100) begin n_err++; $display("FAIL snap_done2 got=%b want=%b", ctl, 5'b01100); end
    tick();
  endtask

  // hold blocks new work; reset during V_REQ aborts immediately.
  task automatic test_hold_reset();
    hold = 1'b1; tgt_v = 6'b00_11_00;
    tick(5);
    n_vec++; if ({vreg_req, busy} !== 2'b00 || cur_v !== 6'b000100) begin n_err++; $display("FAIL hold_idle got=%b/%b want=00/000100", {vreg_req, busy}, cur_v); end
    hold = 1'b0;
    tick();
    n_vec++; if (ctl !== 5'b11001 || {vreg_dom, vreg_lvl} !== 4'b0111) begin n_err++; $display("FAIL hold_release got=%b/%b want=11001/0111", ctl, {vreg_dom, vreg_lvl}); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({vreg_req, busy, done} !== 3'b000) begin n_err++; $display("FAIL rst_abort_ctl got=%b want=000", {vreg_req, busy, done}); end
    n_vec++; if (cur_v !== 6'b010101 || cur_f !== 9'b010010010) begin n_err++; $display("FAIL rst_abort_cur got=%b/%b want=010101/010010010", cur_v, cur_f); end
    tgt_v = 6'b010101; tgt_f = 9'b010010010;
    tick();
    rst_n = 1'b1;
    tick(2);
    n_vec++; if (ctl !== 5'b00000) begin n_err++; $display("FAIL rst_idle got=%b want=%b", ctl, 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_v_up();
    test_f_down();
    test_round_robin();
    test_snapshot();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1);
  end

endmodule
